dff_delay_line: RTL

Parametrised, clock-enabled register delay line for the sequential-logic training block set. It generalises the single-bit edge-triggered register to WIDTH bits and up to DEPTH pipeline stages, with per-stage valid tracking. It adds a runtime-selectable output tap, including a transparent zero-delay tap, plus stall, synchronous flush and a sticky range-error flag. It is used wherever a data path needs a programmable 0..DEPTH cycle delay with valid qualification.

---
 rtl/dff_delay_line.sv | 80 ++++++++
 1 files changed

// File: rtl/dff_delay_line.sv
// Clock-enabled WIDTH x DEPTH register delay line with per-stage valid bits,
// a runtime-selectable output tap (including a zero-delay bypass), flush and sticky range error.
module dff_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned DlyW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_d,
  input  logic [DlyW-1:0]  i_dly,
  output logic [WIDTH-1:0] o_q,
  output logic             o_vld,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [DlyW-1:0] DepthW = DlyW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
  logic [DEPTH-1:0]            v_q, v_d;
  logic                        err_q, err_d;
  logic                        dly_oor;
  logic [DlyW-1:0]             dly_eff;

  assign dly_oor = (i_dly > DepthW);
  assign dly_eff = dly_oor ? DepthW : i_dly;

  // Clear wins over shift; with neither, every stage holds.
  always_comb begin
    s_d = s_q;
    v_d = v_q;
    if (i_clr) begin
      s_d = {DEPTH{RESET_VAL}};
      v_d = '0;
    end else if (i_en) begin
      s_d[0] = i_d;
      v_d[0] = i_vld;
      for (int k = 1; k < DEPTH; k++) begin
        s_d[k] = s_q[k-1];
        v_d[k] = v_q[k-1];
      end
    end
  end

  // The error flag is deliberately immune to i_clr.
  assign err_d = err_q | dly_oor;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s_q   <= {DEPTH{RESET_VAL}};
      v_q   <= '0;
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      v_q   <= v_d;
      err_q <= err_d;
    end
  end

  // Tap d=0 is the unregistered bypass; d=k selects stage k-1.
  always_comb begin
    o_q   = i_d;
    o_vld = i_vld;
    for (int k = 0; k < DEPTH; k++) begin
      if (dly_eff == DlyW'(k + 1)) begin
        o_q   = s_q[k];
        o_vld = v_q[k];
      end
    end
  end

  assign o_busy = |v_q;
  assign o_err  = err_q;

endmodule
